// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: FSM encodings, BCD limit and default timing.
package display_scan_ctrl_pkg;

   localparam logic [0:0] S_BLANK = 1'b0;
   localparam logic [0:0] S_SHOW  = 1'b1;

   localparam int unsigned BCD_MAX   = 9;
   localparam int unsigned DEF_N_DIG = 4;
   localparam int unsigned DEF_PRESC = 250;
   localparam int unsigned DEF_BLANK = 8;

   // True for nibbles that are not a legal decimal digit.
   function automatic logic bcd_invalid(input logic [3:0] d);
      return d > 4'(BCD_MAX);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// Digit-slot prescaler: counts 0..PRESC-1 and flags the dead-time window and last cycle of a slot.
module slot_timer
   import display_scan_ctrl_pkg::*;
#(
   parameter int unsigned PRESC = DEF_PRESC,
   parameter int unsigned BLANK = DEF_BLANK,
   parameter int unsigned CW    = (PRESC > 1) ? $clog2(PRESC) : 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] o_cnt,
   output logic          o_in_blank_c,
   output logic          o_slot_end_c
);

   logic [CW-1:0] r_cnt;

   assign o_cnt        = r_cnt;
   assign o_slot_end_c = (r_cnt == CW'(PRESC - 1));
   assign o_in_blank_c = (r_cnt < CW'(BLANK));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (o_slot_end_c) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one digit per slot with dead time, leading-zero
// blanking, lamp test and a frame-synchronous load handshake.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int unsigned N_DIG = DEF_N_DIG,
   parameter int unsigned PRESC = DEF_PRESC,
   parameter int unsigned BLANK = DEF_BLANK
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*N_DIG-1:0] valor,
   input  logic               cargar,
   output logic               listo,
   input  logic               lz_en,
   input  logic               lamp_test,
   input  logic               apagar,
   output logic [3:0]         dec_bcd,
   output logic               dec_lt_n,
   output logic               dec_bi_n,
   output logic [N_DIG-1:0]   an,
   output logic               frame_tick,
   output logic               err
);

   localparam int unsigned DW = 4 * N_DIG;
   localparam int unsigned IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int unsigned CW = (PRESC > 1) ? $clog2(PRESC) : 1;

   logic [CW-1:0]    w_cnt;
   logic             w_in_blank;
   logic             w_slot_end;
   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [IW-1:0]    r_idx;
   logic [DW-1:0]    r_disp;
   logic [DW-1:0]    r_shadow;
   logic             r_listo;
   logic             r_err;
   logic [N_DIG-1:0] r_an;
   logic [3:0]       r_bcd;
   logic             r_lt_n;
   logic             r_bi_n;
   logic             r_ft;
   logic             w_last;
   logic             w_wrap;
   logic             w_cap;
   logic             w_show;
   logic [3:0]       w_digit;
   logic             w_upper_zero;
   logic             w_shadow_bad;
   logic [N_DIG-1:0] w_an_nxt;
   logic [3:0]       w_bcd_nxt;
   logic             w_lt_n_nxt;
   logic             w_bi_n_nxt;

   slot_timer #(
      .PRESC (PRESC),
      .BLANK (BLANK),
      .CW    (CW)
   ) u_slot_timer (
      .clk          (clk),
      .rst          (rst),
      .o_cnt        (w_cnt),
      .o_in_blank_c (w_in_blank),
      .o_slot_end_c (w_slot_end)
   );

   assign w_last = (r_idx == IW'(N_DIG - 1));
   assign w_wrap = w_slot_end && w_last;
   assign w_cap  = cargar && r_listo;
   assign w_show = (r_state == S_SHOW) && !w_in_blank;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_BLANK;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BLANK: if (w_cnt == CW'(BLANK - 1)) w_state_nxt = S_SHOW;
         S_SHOW:  if (w_slot_end)              w_state_nxt = S_BLANK;
         default: w_state_nxt = S_BLANK;
      endcase
   end

   // Current digit, "this digit and all above are zero", and shadow validity.
   always_comb begin
      w_digit      = 4'd0;
      w_upper_zero = 1'b1;
      w_shadow_bad = 1'b0;
      for (int j = 0; j < int'(N_DIG); j++) begin
         if (IW'(j) == r_idx) w_digit = r_disp[4*j +: 4];
         if (IW'(j) >= r_idx && r_disp[4*j +: 4] != 4'd0) w_upper_zero = 1'b0;
         if (bcd_invalid(r_shadow[4*j +: 4])) w_shadow_bad = 1'b1;
      end
   end

   always_comb begin
      w_an_nxt   = '0;
      w_bcd_nxt  = 4'd0;
      w_lt_n_nxt = 1'b1;
      w_bi_n_nxt = 1'b0;
      if (w_show && !apagar) begin
         w_an_nxt  = N_DIG'(1) << r_idx;
         w_bcd_nxt = w_digit;
         if (lamp_test) begin
            w_lt_n_nxt = 1'b0;
            w_bi_n_nxt = 1'b1;
         end else if (bcd_invalid(w_digit)) begin
            w_bi_n_nxt = 1'b0;
         end else if (lz_en && w_upper_zero && r_idx != '0) begin
            w_bi_n_nxt = 1'b0;
         end else begin
            w_bi_n_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
   end

   // Capture has priority; a commit can only happen while a load is pending (listo low).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_disp   <= '0;
         r_listo  <= 1'b1;
         r_err    <= 1'b0;
      end else if (w_cap) begin
         r_shadow <= valor;
         r_listo  <= 1'b0;
      end else if (w_wrap && !r_listo) begin
         r_disp   <= r_shadow;
         r_listo  <= 1'b1;
         r_err    <= r_err | w_shadow_bad;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_an   <= '0;
         r_bcd  <= 4'd0;
         r_lt_n <= 1'b1;
         r_bi_n <= 1'b0;
         r_ft   <= 1'b0;
      end else begin
         r_an   <= w_an_nxt;
         r_bcd  <= w_bcd_nxt;
         r_lt_n <= w_lt_n_nxt;
         r_bi_n <= w_bi_n_nxt;
         r_ft   <= w_wrap;
      end
   end

   assign an         = r_an;
   assign dec_bcd    = r_bcd;
   assign dec_lt_n   = r_lt_n;
   assign dec_bi_n   = r_bi_n;
   assign frame_tick = r_ft;
   assign listo      = r_listo;
   assign err        = r_err;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESC=10, BLANK=2, N_DIG=4.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] valor;
   logic        cargar;
   logic        listo;
   logic        lz_en;
   logic        lamp_test;
   logic        apagar;
   logic [3:0]  dec_bcd;
   logic        dec_lt_n;
   logic        dec_bi_n;
   logic [3:0]  an;
   logic        frame_tick;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;

   display_scan_ctrl #(
      .N_DIG (4),
      .PRESC (10),
      .BLANK (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valor      (valor),
      .cargar     (cargar),
      .listo      (listo),
      .lz_en      (lz_en),
      .lamp_test  (lamp_test),
      .apagar     (apagar),
      .dec_bcd    (dec_bcd),
      .dec_lt_n   (dec_lt_n),
      .dec_bi_n   (dec_bi_n),
      .an         (an),
      .frame_tick (frame_tick),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One 40-cycle frame starting right after a wrap: i%10 is the slot count, i/10 the digit.
   // lit[d] is the expected dec_bi_n for digit d while it is shown.
   task automatic run_frame(input string tag, input logic [15:0] disp_exp, input logic [3:0] lit,
                            input logic lz, input logic lamp, input logic apg,
                            input logic do_ld, input logic [15:0] ld_val);
      int          cnt;
      int          idx;
      logic        show;
      logic [3:0]  exp_an;
      logic [3:0]  exp_dig;
      lz_en     = lz;
      lamp_test = lamp;
      apagar    = apg;
      for (int i = 0; i < 40; i++) begin
         cargar = 1'b0;
         if (do_ld && i == 5) begin
            cargar = 1'b1;
            valor  = ld_val;
         end else if (do_ld && i == 20) begin
            cargar = 1'b1;
            valor  = ~ld_val;
         end
         tick();
         cargar  = 1'b0;
         cnt     = i % 10;
         idx     = i / 10;
         show    = (cnt >= 2) && !apg;
         exp_an  = show ? (4'b0001 << idx) : 4'b0000;
         exp_dig = disp_exp[4*idx +: 4];
         chk({tag, " an"}, 16'(an), 16'(exp_an));
         chk({tag, " bi_n"}, 16'(dec_bi_n), show ? 16'(lit[idx]) : 16'd0);
         chk({tag, " lt_n"}, 16'(dec_lt_n), (show && lamp) ? 16'd0 : 16'd1);
         chk({tag, " frame_tick"}, 16'(frame_tick), (i == 39) ? 16'd1 : 16'd0);
         if (show) chk({tag, " bcd"}, 16'(dec_bcd), 16'(exp_dig));
         if (do_ld && i >= 5) chk({tag, " listo"}, 16'(listo), (i == 39) ? 16'd1 : 16'd0);
         else                 chk({tag, " listo"}, 16'(listo), 16'd1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      valor     = 16'h0000;
      cargar    = 1'b0;
      lz_en     = 1'b0;
      lamp_test = 1'b0;
      apagar    = 1'b0;
      tick();
      chk("rst an", 16'(an), 16'd0);
      chk("rst bi_n", 16'(dec_bi_n), 16'd0);
      chk("rst lt_n", 16'(dec_lt_n), 16'd1);
      chk("rst bcd", 16'(dec_bcd), 16'd0);
      chk("rst listo", 16'(listo), 16'd1);
      chk("rst err", 16'(err), 16'd0);
      chk("rst frame_tick", 16'(frame_tick), 16'd0);
      rst = 1'b0;

      run_frame("free",     16'h0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      run_frame("load42",   16'h0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042);
      run_frame("show42",   16'h0042, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      run_frame("lz42",     16'h0042, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
      run_frame("lz00",     16'h0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      run_frame("lamp",     16'h0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("err before A3", 16'(err), 16'd0);
      run_frame("apagar",   16'h0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A3);
      chk("err after A3", 16'(err), 16'd1);
      run_frame("showA3",   16'h00A3, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      chk("err sticky", 16'(err), 16'd1);

      // Mid-slot reset with a load still pending.
      valor  = 16'h0999;
      cargar = 1'b1;
      tick();
      cargar = 1'b0;
      chk("mid pending listo", 16'(listo), 16'd0);
      for (int k = 0; k < 12; k++) tick();
      chk("mid an", 16'(an), 16'b0010);
      rst = 1'b1;
      tick();
      chk("mid rst an", 16'(an), 16'd0);
      chk("mid rst bi_n", 16'(dec_bi_n), 16'd0);
      chk("mid rst lt_n", 16'(dec_lt_n), 16'd1);
      chk("mid rst bcd", 16'(dec_bcd), 16'd0);
      chk("mid rst listo", 16'(listo), 16'd1);
      chk("mid rst err", 16'(err), 16'd0);
      chk("mid rst frame_tick", 16'(frame_tick), 16'd0);
      rst = 1'b0;
      tick();
      chk("post rst an c1", 16'(an), 16'd0);
      tick();
      chk("post rst an c2", 16'(an), 16'd0);
      tick();
      chk("post rst an c3", 16'(an), 16'b0001);
      chk("post rst bcd", 16'(dec_bcd), 16'd0);
      chk("post rst bi_n", 16'(dec_bi_n), 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
